cpu_clk_ctrl: RTL
=================

Name: cpu_clk_ctrl

Overview:
- Clock-enable controller for the CPU datapath, running in the clk200m domain.
- Generates a single-cycle clk_en strobe in one of three modes:
  - full-speed run;
  - slow run, paced by a selectable bit of an internal free-running divider;
  - single-step, one strobe per button press.
- Provides a halt handshake for the debug unit and a retired-strobe counter for the display.
- Sits between the board clock/button inputs and every clock-enabled CPU register.

Parameters:
- DIV_W, 32, width of internal divider counter divcnt.
- DEB_CYCLES, 2000000, stable-sample count for step debounce (used only with DEBOUNCE_EN; 10 ms at 200 MHz).

Ports:
- clk200m  input  1  200 MHz system clock.
- rst  input  1  reset, asynchronous, active-high.
- mode  input  2  00 run, 01 slow, 10 step, 11 treated as step.
- div_sel  input  5  divcnt bit index used in slow mode.
- step_btn  input  1  raw asynchronous step push-button.
- halt_req  input  1  level request to freeze the CPU.
- halt_ack  output  1  high while halted.
- clk_en  output  1  one-cycle CPU advance strobe, registered.
- cyc_cnt  output  32  number of clk_en strobes issued.
- divcnt  output  DIV_W  free-running divider value, exported for LED and seven-segment scan.

Behaviour:
- Reset values: clk_en=0, halt_ack=0, cyc_cnt=0, divcnt=0, FSM=RUN, step synchronizer and edge registers=0.
- divcnt:
  - Increments by 1 every clk200m cycle.
  - Wraps from all-ones to 0.
  - Never stops, including while HALTED.
- mode is registered once (mode_q). All decisions use mode_q, so a mode change takes effect 1 cycle after it is sampled.
- FSM states: RUN, SLOW, STEP, HALTED.
  - From RUN, SLOW or STEP: if halt_req=1, go to HALTED. Otherwise go to the state selected by mode_q.
  - HALTED: stay while halt_req=1. When halt_req=0, go to the state selected by mode_q.
- Strobe generation (clk_en is registered; value shown is what appears on the next cycle):
  - RUN: clk_en=1 every cycle.
  - SLOW: tick = divcnt[div_sel]==1 AND the previous-cycle sample of that bit ==0, i.e. a rising edge of the selected bit. clk_en=tick.
    - A div_sel change may produce one spurious or missed tick. This is acceptable.
  - STEP: clk_en=1 for exactly one cycle per step_edge; otherwise 0.
  - HALTED: clk_en=0.
- Halt precedence: when halt_req rises in the same cycle as a pending tick or step_edge, halt wins and the tick is dropped.
- halt_ack is registered:
  - Rises 1 cycle after FSM enters HALTED, i.e. 2 cycles after halt_req is sampled high.
  - Falls the cycle the FSM leaves HALTED.
  - clk_en is guaranteed 0 in every cycle where halt_ack=1.
- step path (DEBOUNCE_EN off):
  - 2-flop synchronizer, then rising-edge detect producing step_edge.
  - clk_en appears 3 cycles after step_btn rises.
  - step_edge occurring outside STEP state is discarded, not queued.
- cyc_cnt:
  - Increments by 1 on each cycle where clk_en=1.
  - Wraps 0xFFFFFFFF to 0.
  - Never saturates.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight strobe is lost. After release the FSM starts in RUN.

Optional Feature:
- Macro: CPU_CLK_DEBOUNCE_EN.
- Defined:
  - A debounce filter is inserted after the synchronizer. The filtered level changes only after the synchronized level has been stable for DEB_CYCLES consecutive cycles.
  - step_edge is the rising edge of the filtered level.
  - Latency from a clean press to clk_en is DEB_CYCLES+3 cycles.
  - Bounces shorter than DEB_CYCLES produce no strobe.
- Undefined:
  - No filter, so every synchronized rising edge yields a strobe (bounces may multi-step).
  - DEB_CYCLES is unused.

Test Plan:
- Reset release with mode=00, halt_req=0 -> clk_en=1 from the 2nd cycle onward; cyc_cnt=100 after 100 strobes; divcnt counts 0,1,2,...
- mode=01, div_sel=3 -> exactly one clk_en pulse per 16 cycles, each aligned to divcnt[3] rising; cyc_cnt +4 over 64 cycles.
- mode=10, DEBOUNCE_EN off, step_btn high for 10 cycles -> exactly one clk_en pulse, 3 cycles after the rise; a second press gives a second pulse; cyc_cnt=2.
- mode=00, halt_req asserted at cycle N:
  - halt_ack=1 at N+2 and clk_en=0 from N+2 onward;
  - halt_req dropped -> halt_ack=0 and clk_en resumes within 2 cycles;
  - a step press during halt in mode=10 produces no pulse.
- Preload cyc_cnt to 0xFFFFFFFE via forced run -> after 2 strobes cyc_cnt=0x00000000; divcnt wrap from 0xFFFFFFFF to 0 is continuous.
- DEBOUNCE_EN on, DEB_CYCLES=8:
  - 3-cycle glitch -> no pulse;
  - 20-cycle press -> one pulse at 11 cycles after the rise;
  - rst asserted during a press -> clk_en=0, cyc_cnt=0 immediately.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl -- clock-enable controller for the CPU datapath (clk200m domain).
//
// Produces a registered single-cycle clk_en strobe in one of three modes:
//   mode 00 : full-speed run, strobe every cycle
//   mode 01 : slow run, strobe on each rising edge of divcnt[div_sel]
//   mode 10 : single-step, one strobe per step_btn press (11 behaves as 10)
// A level halt_req freezes the CPU. halt_ack is asserted once the freeze is
// established. cyc_cnt counts issued strobes and divcnt free-runs for display
// scanning.
//
// Optional build macro: CPU_CLK_DEBOUNCE_EN
//   When defined, a debounce filter sits between the step synchronizer and the
//   edge detector. The filtered level follows the synchronized level only after
//   it has been stable for DEB_CYCLES cycles. When undefined, DEB_CYCLES has no
//   effect and every synchronized rising edge of step_btn yields a strobe.
//
// Handshake: halt_req is a level. The FSM enters HALTED on the first edge that
// samples it high, and halt_ack follows one cycle later. halt_ack drops on the
// same edge at which the FSM leaves HALTED. clk_en is never high while
// halt_ack is high.

module cpu_clk_ctrl #(
   parameter int DIV_W      = 32,
   parameter int DEB_CYCLES = 2000000
) (
   input  logic             clk200m,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [4:0]       div_sel,
   input  logic             step_btn,
   input  logic             halt_req,
   output logic             halt_ack,
   output logic             clk_en,
   output logic [31:0]      cyc_cnt,
   output logic [DIV_W-1:0] divcnt
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_SLOW   = 2'd1;
   localparam logic [1:0] ST_STEP   = 2'd2;
   localparam logic [1:0] ST_HALTED = 2'd3;

   logic [1:0] mode_q;
   logic [1:0] state;
   logic [1:0] state_nxt;
   logic [1:0] mode_state;
   logic       sel_q;
   logic       tick;
   logic       step_sync1;
   logic       step_sync2;
   logic       step_lvl;
   logic       step_lvl_q;
   logic       step_edge;
   logic       strobe;

   // Free-running divider; wraps naturally and ignores halt.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) divcnt <= '0;
      else     divcnt <= divcnt + {{(DIV_W-1){1'b0}}, 1'b1};
   end

   // Register mode once so every decision sees a stable value.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) mode_q <= 2'b00;
      else     mode_q <= mode;
   end

   // Map the registered mode onto its running state (11 folds into step).
   always_comb begin
      mode_state = ST_STEP;
      case (mode_q)
         2'b00:   mode_state = ST_RUN;
         2'b01:   mode_state = ST_SLOW;
         default: mode_state = ST_STEP;
      endcase
   end

   // Next state: halt_req wins from every state, otherwise follow mode_q.
   always_comb begin
      state_nxt = mode_state;
      if (halt_req) state_nxt = ST_HALTED;
   end

   // FSM state register.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   // Previous-cycle sample of the selected divider bit for edge detection.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) sel_q <= 1'b0;
      else     sel_q <= divcnt[div_sel];
   end

   assign tick = divcnt[div_sel] & ~sel_q;

   // Two-flop synchronizer for the raw push-button.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) begin
         step_sync1 <= 1'b0;
         step_sync2 <= 1'b0;
      end else begin
         step_sync1 <= step_btn;
         step_sync2 <= step_sync1;
      end
   end

`ifdef CPU_CLK_DEBOUNCE_EN
   logic [31:0] deb_cnt;
   logic        step_filt;

   // Debounce: adopt the synchronized level after DEB_CYCLES stable cycles.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) begin
         deb_cnt   <= '0;
         step_filt <= 1'b0;
      end else if (step_sync2 == step_filt) begin
         deb_cnt <= '0;
      end else if (deb_cnt == 32'(DEB_CYCLES - 1)) begin
         deb_cnt   <= '0;
         step_filt <= step_sync2;
      end else begin
         deb_cnt <= deb_cnt + 32'd1;
      end
   end

   assign step_lvl = step_filt;
`else
   // No filter in this build; DEB_CYCLES is tied off here.
   logic unused_deb;
   assign unused_deb = (DEB_CYCLES == 0);
   assign step_lvl   = step_sync2;
`endif

   // Delayed step level for rising-edge detection.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) step_lvl_q <= 1'b0;
      else     step_lvl_q <= step_lvl;
   end

   assign step_edge = step_lvl & ~step_lvl_q;

   // Candidate strobe for the current state; edges outside STEP are dropped.
   always_comb begin
      strobe = 1'b0;
      case (state)
         ST_RUN:  strobe = 1'b1;
         ST_SLOW: strobe = tick;
         ST_STEP: strobe = step_edge;
         default: strobe = 1'b0;
      endcase
   end

   // Registered outputs: halt_req suppresses a same-cycle strobe, and
   // halt_ack holds only while the FSM stays in HALTED.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst) begin
         clk_en   <= 1'b0;
         halt_ack <= 1'b0;
      end else begin
         clk_en   <= strobe & ~halt_req;
         halt_ack <= (state == ST_HALTED) && (state_nxt == ST_HALTED);
      end
   end

   // Strobe counter, wraps without saturating.
   always_ff @(posedge clk200m or posedge rst) begin
      if (rst)         cyc_cnt <= '0;
      else if (clk_en) cyc_cnt <= cyc_cnt + 32'd1;
   end

endmodule
